// File: rtl/muldiv_unit_if.sv
// muldiv_unit_if: EX-stage <-> multiply/divide unit connection.
//   start/op/src_a/src_b : operation issue
//   flush                : abort any in-flight op
//   hilo_rdata           : current {HI,LO} (write-forwarded)
//   busy                 : op in flight
//   hilo_we/hilo_wdata   : one-cycle {HI,LO} write
// master = pipeline side, slave = muldiv_unit.
interface muldiv_unit_if;
  logic        start;
  logic [2:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        flush;
  logic [63:0] hilo_rdata;
  logic        busy;
  logic        hilo_we;
  logic [63:0] hilo_wdata;

  modport master (
    output start, op, src_a, src_b, flush, hilo_rdata,
    input  busy, hilo_we, hilo_wdata
  );

  modport slave (
    input  start, op, src_a, src_b, flush, hilo_rdata,
    output busy, hilo_we, hilo_wdata
  );
endinterface

// File: rtl/muldiv_unit.sv
// muldiv_unit: write side of the HI/LO register pair.
//   MULT/MULTU/MTHI/MTLO complete one cycle after issue; DIV/DIVU run a
//   radix-2 restoring divider (one quotient bit per cycle) and write 33
//   cycles after issue. Result is driven as a one-cycle {HI,LO} write.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   bus      : muldiv_unit_if.slave (issue, flush, HI/LO read/write, busy)
// Optional feature macro: MDU_MADD_EN enables MADD (110) / MSUB (111),
//   which accumulate the signed product into hilo_rdata sampled in EXEC.
//   Without it those encodings are ignored.
module muldiv_unit #(
  parameter int unsigned DIV_ITERS = 32
) (
  input logic          clk,
  input logic          rst,
  muldiv_unit_if.slave bus
);

  typedef enum logic [1:0] {IDLE, EXEC, DIV_RUN, DONE} state_e;
  typedef enum logic [2:0] {
    OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MTHI, OP_MTLO, OP_MADD, OP_MSUB
  } op_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, dvd_q, dvd_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d;
  logic [63:0] res_q, res_d, wdata_q, wdata_d;
`ifdef MDU_MADD_EN
  op_e         op_q, op_d;
`endif

  op_e         op_in;
  logic        legal, accept, is_div, is_signed;
  logic [31:0] a_mag, b_mag, rem_n, quo_n;
  logic [32:0] shifted, diff;
  logic [63:0] exec_res;

  always_comb begin
    op_in = op_e'(bus.op);
`ifdef MDU_MADD_EN
    legal = 1'b1;
`else
    legal = (op_in != OP_MADD) && (op_in != OP_MSUB);
`endif
    accept    = bus.start & ~bus.flush & legal;
    is_div    = (op_in == OP_DIV) || (op_in == OP_DIVU);
    is_signed = (op_in == OP_DIV);
    a_mag     = (is_signed && bus.src_a[31]) ? -bus.src_a : bus.src_a;
    b_mag     = (is_signed && bus.src_b[31]) ? -bus.src_b : bus.src_b;

    // One restoring step: shift in the next dividend bit, try subtracting.
    shifted = {rem_q, quo_q[31]};
    diff    = shifted - {1'b0, dvs_q};
    rem_n   = diff[32] ? shifted[31:0] : diff[31:0];
    quo_n   = {quo_q[30:0], ~diff[32]};

`ifdef MDU_MADD_EN
    // Accumulate ops read HI/LO in EXEC to see a write landing the cycle before.
    case (op_q)
      OP_MADD: exec_res = bus.hilo_rdata + res_q;
      OP_MSUB: exec_res = bus.hilo_rdata - res_q;
      default: exec_res = res_q;
    endcase
`else
    exec_res = res_q;
`endif
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    dvd_d   = dvd_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    res_d   = res_q;
    wdata_d = wdata_q;
`ifdef MDU_MADD_EN
    op_d    = op_q;
`endif
    case (state_q)
      IDLE: if (accept) begin
`ifdef MDU_MADD_EN
        op_d  = op_in;
`endif
        dvd_d = bus.src_a;
        if (is_div) begin
          state_d = DIV_RUN;
          cnt_d   = '0;
          rem_d   = '0;
          quo_d   = a_mag;
          dvs_d   = b_mag;
          qneg_d  = is_signed & (bus.src_a[31] ^ bus.src_b[31]);
          rneg_d  = is_signed & bus.src_a[31];
        end else begin
          state_d = EXEC;
          case (op_in)
            OP_MULTU: res_d = {32'b0, bus.src_a} * {32'b0, bus.src_b};
            OP_MTHI:  res_d = {bus.src_a, bus.hilo_rdata[31:0]};
            OP_MTLO:  res_d = {bus.hilo_rdata[63:32], bus.src_a};
            default:  res_d = $signed({{32{bus.src_a[31]}}, bus.src_a})
                            * $signed({{32{bus.src_b[31]}}, bus.src_b});
          endcase
        end
      end
      // Single-cycle ops write directly from EXEC (it plays the DONE role),
      // so they return to IDLE here to keep exactly one write.
      EXEC: begin
        state_d = IDLE;
        wdata_d = exec_res;
      end
      DIV_RUN: begin
        rem_d = rem_n;
        quo_d = quo_n;
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == 6'(DIV_ITERS - 1)) begin
          state_d = DONE;
          if (dvs_q == '0)
            wdata_d = {dvd_q, 32'hFFFF_FFFF};
          else
            wdata_d = {rneg_q ? -rem_n : rem_n, qneg_q ? -quo_n : quo_n};
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d = IDLE;
      wdata_d = wdata_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      dvd_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      res_q   <= '0;
      wdata_q <= '0;
`ifdef MDU_MADD_EN
      op_q    <= OP_MULT;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      dvd_q   <= dvd_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      res_q   <= res_d;
      wdata_q <= wdata_d;
`ifdef MDU_MADD_EN
      op_q    <= op_d;
`endif
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.hilo_we    = ((state_q == EXEC) || (state_q == DONE)) & ~bus.flush;
  assign bus.hilo_wdata = ((state_q == EXEC) && !bus.flush) ? exec_res : wdata_q;

endmodule

// File: tb/tb_muldiv_unit.sv
module tb_muldiv_unit;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  muldiv_unit_if bus();
  muldiv_unit dut (.clk(clk), .rst(rst), .bus(bus));

  typedef struct {
    int unsigned cyc;
    logic [63:0] data;
  } wr_t;

  wr_t         exp_q[$];
  wr_t         got_q[$];
  int unsigned cyc = 0;
  int          n_cmp = 0;
  int          n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (!rst && bus.hilo_we) got_q.push_back('{cyc: cyc, data: bus.hilo_wdata});

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                                        input logic [63:0] rd);
    int sa, sb, q, r;
    sa = a; sb = b;
    case (op)
      3'd0: model = longint'(sa) * longint'(sb);
      3'd1: model = {32'b0, a} * {32'b0, b};
      3'd2: begin
        if (b == 0) model = {a, 32'hFFFF_FFFF};
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) model = {32'h0, 32'h8000_0000};
        else begin q = sa / sb; r = sa % sb; model = {r, q}; end
      end
      3'd3: model = (b == 0) ? {a, 32'hFFFF_FFFF} : {a % b, a / b};
      3'd4: model = {a, rd[31:0]};
      default: model = {rd[63:32], a};
    endcase
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       output int unsigned t0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = op; bus.src_a = a; bus.src_b = b;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0;
  endtask

  task automatic test_reset();
    int unsigned t0;
    rst = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.src_a = '0; bus.src_b = '0;
    bus.flush = 1'b0; bus.hilo_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b required 0", bus.busy); end
    n_cmp++; if (bus.hilo_we !== 1'b0) begin n_fail++; $display("FAIL reset_we: got %b required 0", bus.hilo_we); end
    n_cmp++; if (bus.hilo_wdata !== 64'h0) begin n_fail++; $display("FAIL reset_wdata: got %h required 0", bus.hilo_wdata); end
    rst = 1'b0;
    // Make wdata nonzero, then reset in the middle of a divide.
    issue(3'd1, 32'h1234_5678, 32'h10, t0);
    exp_q.push_back('{cyc: t0 + 1, data: 64'h0000_0001_2345_6780});
    issue(3'd3, 32'd100, 32'd7, t0);
    repeat (5) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL midreset_busy: got %b required 0", bus.busy); end
    n_cmp++; if (bus.hilo_wdata !== 64'h0) begin n_fail++; $display("FAIL midreset_wdata: got %h required 0", bus.hilo_wdata); end
    repeat (40) @(negedge clk);
    while (exp_q.size() > 0) begin
      wr_t e, g;
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL reset_write: no write, required %h @%0d", e.data, e.cyc); end
      else begin
        g = got_q.pop_front();
        if (g.data !== e.data || g.cyc !== e.cyc) begin
          n_fail++; $display("FAIL reset_write: got %h @%0d required %h @%0d", g.data, g.cyc, e.data, e.cyc);
        end
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL reset_extra_writes: got %0d required 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_mult();
    int unsigned t0;
    issue(3'd0, 32'hFFFF_FFFE, 32'd3, t0);
    exp_q.push_back('{cyc: t0 + 1, data: 64'hFFFF_FFFF_FFFF_FFFA});
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL mult_busy_c1: got %b required 1", bus.busy); end
    issue(3'd1, 32'hFFFF_FFFE, 32'd3, t0);
    exp_q.push_back('{cyc: t0 + 1, data: 64'h0000_0002_FFFF_FFFA});
    repeat (4) @(negedge clk);
    n_cmp++; if (bus.hilo_wdata !== 64'h0000_0002_FFFF_FFFA) begin
      n_fail++; $display("FAIL mult_wdata_hold: got %h required 00000002fffffffa", bus.hilo_wdata);
    end
    while (exp_q.size() > 0) begin
      wr_t e, g;
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL mult_write: no write, required %h @%0d", e.data, e.cyc); end
      else begin
        g = got_q.pop_front();
        if (g.data !== e.data || g.cyc !== e.cyc) begin
          n_fail++; $display("FAIL mult_write: got %h @%0d required %h @%0d", g.data, g.cyc, e.data, e.cyc);
        end
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL mult_extra_writes: got %0d required 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_div();
    int unsigned t0;
    issue(3'd2, -32'sd7, 32'd2, t0);
    exp_q.push_back('{cyc: t0 + 33, data: 64'hFFFF_FFFF_FFFF_FFFD});
    for (int k = 1; k <= 34; k++) begin
      @(negedge clk);
      n_cmp++;
      if (bus.busy !== (k <= 33)) begin n_fail++; $display("FAIL div_busy_c%0d: got %b required %b", k, bus.busy, k <= 33); end
    end
    issue(3'd3, 32'd100, 32'd7, t0);
    exp_q.push_back('{cyc: t0 + 33, data: 64'h0000_0002_0000_000E});
    repeat (34) @(negedge clk);
    issue(3'd3, 32'd100, 32'd0, t0);
    exp_q.push_back('{cyc: t0 + 33, data: 64'h0000_0064_FFFF_FFFF});
    repeat (34) @(negedge clk);
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, t0);
    exp_q.push_back('{cyc: t0 + 33, data: 64'h0000_0000_8000_0000});
    repeat (34) @(negedge clk);
    while (exp_q.size() > 0) begin
      wr_t e, g;
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL div_write: no write, required %h @%0d", e.data, e.cyc); end
      else begin
        g = got_q.pop_front();
        if (g.data !== e.data || g.cyc !== e.cyc) begin
          n_fail++; $display("FAIL div_write: got %h @%0d required %h @%0d", g.data, g.cyc, e.data, e.cyc);
        end
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL div_extra_writes: got %0d required 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_flush();
    int unsigned t0, t1;
    issue(3'd2, 32'd1000, 32'd3, t0);
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    bus.start = 1'b1; bus.op = 3'd0; bus.src_a = 32'd5; bus.src_b = 32'd6;
    t1 = cyc;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_busy_c11: got %b required 0", bus.busy); end
    @(posedge clk); #1 bus.start = 1'b0;
    exp_q.push_back('{cyc: t1 + 1, data: 64'h0000_0000_0000_001E});
    repeat (30) @(negedge clk);
    // Flush during DONE must drop the write.
    issue(3'd3, 32'd100, 32'd7, t0);
    repeat (32) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(negedge clk);
    n_cmp++; if (bus.hilo_we !== 1'b0) begin n_fail++; $display("FAIL flush_done_we: got %b required 0", bus.hilo_we); end
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk);
    n_cmp++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL flush_done_busy: got %b required 0", bus.busy); end
    repeat (3) @(negedge clk);
    while (exp_q.size() > 0) begin
      wr_t e, g;
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL flush_write: no write, required %h @%0d", e.data, e.cyc); end
      else begin
        g = got_q.pop_front();
        if (g.data !== e.data || g.cyc !== e.cyc) begin
          n_fail++; $display("FAIL flush_write: got %h @%0d required %h @%0d", g.data, g.cyc, e.data, e.cyc);
        end
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL flush_extra_writes: got %0d required 0", got_q.size()); end
    got_q.delete();
  endtask

  task automatic test_mt();
    int unsigned t0;
    bus.hilo_rdata = 64'hAAAA_AAAA_BBBB_BBBB;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'd4; bus.src_a = 32'h1234_5678;
    t0 = cyc;
    @(posedge clk); #1;
    // Second start while busy, plus HI/LO changing after cycle 0.
    bus.op = 3'd5; bus.src_a = 32'hDEAD_BEEF; bus.hilo_rdata = '0;
    @(posedge clk); #1 bus.start = 1'b0;
    exp_q.push_back('{cyc: t0 + 1, data: 64'h1234_5678_BBBB_BBBB});
    bus.hilo_rdata = 64'hAAAA_AAAA_BBBB_BBBB;
    issue(3'd5, 32'hCAFE_F00D, 32'd0, t0);
    exp_q.push_back('{cyc: t0 + 1, data: 64'hAAAA_AAAA_CAFE_F00D});
    repeat (4) @(negedge clk);
    while (exp_q.size() > 0) begin
      wr_t e, g;
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL mt_write: no write, required %h @%0d", e.data, e.cyc); end
      else begin
        g = got_q.pop_front();
        if (g.data !== e.data || g.cyc !== e.cyc) begin
          n_fail++; $display("FAIL mt_write: got %h @%0d required %h @%0d", g.data, g.cyc, e.data, e.cyc);
        end
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL mt_extra_writes: got %0d required 0", got_q.size()); end
    got_q.delete();
  endtask

`ifdef MDU_MADD_EN
  task automatic test_madd();
    int unsigned t0;
    bus.hilo_rdata = 64'd100;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = 3'd6; bus.src_a = 32'd2; bus.src_b = 32'd3;
    t0 = cyc;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.hilo_rdata = 64'd1;
    exp_q.push_back('{cyc: t0 + 1, data: 64'h0000_0000_0000_0007});
    issue(3'd7, 32'd2, 32'd3, t0);
    exp_q.push_back('{cyc: t0 + 1, data: 64'hFFFF_FFFF_FFFF_FFFB});
    repeat (4) @(negedge clk);
    while (exp_q.size() > 0) begin
      wr_t e, g;
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL madd_write: no write, required %h @%0d", e.data, e.cyc); end
      else begin
        g = got_q.pop_front();
        if (g.data !== e.data || g.cyc !== e.cyc) begin
          n_fail++; $display("FAIL madd_write: got %h @%0d required %h @%0d", g.data, g.cyc, e.data, e.cyc);
        end
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL madd_extra_writes: got %0d required 0", got_q.size()); end
    got_q.delete();
  endtask
`else
  task automatic test_illegal();
    for (int o = 6; o <= 7; o++) begin
      int busy_hits;
      busy_hits = 0;
      @(posedge clk); #1;
      bus.start = 1'b1; bus.op = 3'(o); bus.src_a = 32'd2; bus.src_b = 32'd3;
      @(posedge clk); #1 bus.start = 1'b0;
      repeat (40) begin @(negedge clk); if (bus.busy !== 1'b0) busy_hits++; end
      n_cmp++; if (busy_hits != 0) begin n_fail++; $display("FAIL illegal_busy op%0d: got %0d busy cycles required 0", o, busy_hits); end
    end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL illegal_writes: got %0d required 0", got_q.size()); end
    got_q.delete();
  endtask
`endif

  task automatic test_back_to_back();
    int unsigned t0, guard;
    logic [2:0]  op;
    logic [31:0] a, b;
    for (int i = 0; i < 12; i++) begin
      op = 3'($urandom_range(0, 5));
      a  = $urandom;
      b  = (op inside {3'd2, 3'd3} && $urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      bus.hilo_rdata = {$urandom, $urandom};
      issue(op, a, b, t0);
      exp_q.push_back('{cyc: t0 + ((op inside {3'd2, 3'd3}) ? 33 : 1), data: model(op, a, b, bus.hilo_rdata)});
      guard = 0;
      do begin @(negedge clk); guard++; end while (bus.busy && guard < 40);
      if (guard >= 40) begin n_cmp++; n_fail++; $display("FAIL b2b_timeout op%0d: busy stuck, required idle within 40 cycles", op); end
    end
    while (exp_q.size() > 0) begin
      wr_t e, g;
      e = exp_q.pop_front(); n_cmp++;
      if (got_q.size() == 0) begin n_fail++; $display("FAIL b2b_write: no write, required %h @%0d", e.data, e.cyc); end
      else begin
        g = got_q.pop_front();
        if (g.data !== e.data || g.cyc !== e.cyc) begin
          n_fail++; $display("FAIL b2b_write: got %h @%0d required %h @%0d", g.data, g.cyc, e.data, e.cyc);
        end
      end
    end
    n_cmp++; if (got_q.size() != 0) begin n_fail++; $display("FAIL b2b_extra_writes: got %0d required 0", got_q.size()); end
    got_q.delete();
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_flush();
    test_mt();
`ifdef MDU_MADD_EN
    test_madd();
`else
    test_illegal();
`endif
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
